// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
package imem_loader_pkg;

   localparam int LDR_HDR_BYTES  = 4;
   localparam int LDR_LEN_W      = LDR_HDR_BYTES * 8;
   localparam int DEF_MEM_WIDTH  = 8;
   localparam int DEF_PC_WIDTH   = 32;
   localparam int DEF_IMEM_DEPTH = 1024;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } ld_state_e;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'b00,
      ERR_LEN_RANGE = 2'b01,
      ERR_LEN_ALIGN = 2'b10,
      ERR_CSUM      = 2'b11
   } ld_err_e;

endpackage

// File: rtl/ld_checksum.sv
// 8-bit wrapping byte accumulator; o_zero flags that adding i_byte would give 0 mod 256.
module ld_checksum (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_clr,
   input  logic       i_add,
   input  logic [7:0] i_byte,
   output logic       o_zero
);

   logic [7:0] r_sum;
   logic [7:0] w_sum_next;

   assign w_sum_next = r_sum + i_byte;
   assign o_zero     = (w_sum_next == 8'd0);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sum <= 8'd0;
      end else if (i_clr) begin
         r_sum <= 8'd0;
      end else if (i_add) begin
         r_sum <= w_sum_next;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams length/payload/checksum bytes into IMEM at addresses 0..L-1; writes land one cycle
// after acceptance, in_ready holds off input outside LEN/DATA/CSUM, and wr_en freezes fetch while loading.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
   parameter int PC_WIDTH   = DEF_PC_WIDTH,
   parameter int IMEM_DEPTH = DEF_IMEM_DEPTH
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_start,
   input  logic                 i_in_valid,
   input  logic [7:0]           i_in_data,
   output logic                 o_in_ready,
   output logic                 o_wr_en,
   output logic                 o_mem_we,
   output logic [PC_WIDTH-1:0]  o_mem_addr,
   output logic [MEM_WIDTH-1:0] o_mem_wdata,
   output logic                 o_load_done,
   output logic                 o_load_err,
   output logic [1:0]           o_err_code
);

   ld_state_e              r_state, w_next;
   ld_err_e                r_err_code, w_err_code;
   logic [LDR_LEN_W-1:0]   r_len;
   logic [PC_WIDTH-1:0]    r_cnt;
   logic                   r_in_ready, r_wr_en, r_mem_we, r_done, r_err;
   logic [PC_WIDTH-1:0]    r_mem_addr;
   logic [MEM_WIDTH-1:0]   r_mem_wdata;

   logic                   w_acc, w_start_acc, w_busy_next;
   logic                   w_hdr_last, w_data_last, w_csum_ok;
   logic                   w_done_set, w_err_set;
   logic [LDR_LEN_W-1:0]   w_len_full;

   assign w_acc       = i_in_valid && r_in_ready;
   assign w_start_acc = i_start && (r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERR);
   // Length arrives LSB first, so each new byte shifts in from the top.
   assign w_len_full  = {i_in_data, r_len[LDR_LEN_W-1:8]};
   assign w_hdr_last  = (r_cnt == PC_WIDTH'(LDR_HDR_BYTES - 1));
   assign w_data_last = (LDR_LEN_W'(r_cnt) + LDR_LEN_W'(1) == r_len);
   assign w_busy_next = (w_next == ST_LEN) || (w_next == ST_DATA) || (w_next == ST_CSUM);

   ld_checksum u_csum (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (w_start_acc),
      .i_add     (w_acc && (r_state == ST_DATA)),
      .i_byte    (i_in_data),
      .o_zero    (w_csum_ok)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= ST_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_err_code = ERR_NONE;
      w_err_set  = 1'b0;
      w_done_set = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (i_start) w_next = ST_LEN;
         end
         ST_LEN: begin
            if (w_acc && w_hdr_last) begin
               if (w_len_full > LDR_LEN_W'(IMEM_DEPTH)) begin
                  w_next = ST_ERR; w_err_set = 1'b1; w_err_code = ERR_LEN_RANGE;
               end else if (w_len_full[1:0] != 2'b00) begin
                  w_next = ST_ERR; w_err_set = 1'b1; w_err_code = ERR_LEN_ALIGN;
               end else if (w_len_full == '0) begin
                  w_next = ST_CSUM;
               end else begin
                  w_next = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (w_acc && w_data_last) w_next = ST_CSUM;
         end
         ST_CSUM: begin
            if (w_acc) begin
               if (w_csum_ok) begin
                  w_next = ST_DONE; w_done_set = 1'b1;
               end else begin
                  w_next = ST_ERR; w_err_set = 1'b1; w_err_code = ERR_CSUM;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_in_ready  <= 1'b0;
         r_wr_en     <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
      end else begin
         r_in_ready <= w_busy_next;
         r_wr_en    <= w_busy_next;
         r_mem_we   <= 1'b0;
         if (w_start_acc) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
         end
         if (w_acc && r_state == ST_LEN) begin
            r_len <= w_len_full;
            r_cnt <= w_hdr_last ? '0 : r_cnt + PC_WIDTH'(1);
         end
         if (w_acc && r_state == ST_DATA) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_cnt;
            r_mem_wdata <= MEM_WIDTH'(i_in_data);
            r_cnt       <= r_cnt + PC_WIDTH'(1);
         end
         if (w_done_set) r_done <= 1'b1;
         if (w_err_set) begin
            r_err      <= 1'b1;
            r_err_code <= w_err_code;
         end
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_wr_en     = r_wr_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_load_done = r_done;
   assign o_load_err  = r_err;
   assign o_err_code  = r_err_code;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: status vectors and IMEM write traffic against hand-computed values.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_in_valid = 1'b0;
   logic [7:0]  i_in_data = 8'h00;
   logic        o_in_ready, o_wr_en, o_mem_we, o_load_done, o_load_err;
   logic [31:0] o_mem_addr;
   logic [7:0]  o_mem_wdata;
   logic [1:0]  o_err_code;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0]  pay [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
   logic [31:0] wq_addr [$];
   logic [7:0]  wq_data [$];
   logic        wq_wen  [$];

   // {load_done, load_err, err_code[1:0], wr_en, in_ready, mem_we}
   wire [6:0] stat = {o_load_done, o_load_err, o_err_code, o_wr_en, o_in_ready, o_mem_we};

   imem_loader #(.MEM_WIDTH(8), .PC_WIDTH(32), .IMEM_DEPTH(64)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_start     (i_start),
      .i_in_valid  (i_in_valid),
      .i_in_data   (i_in_data),
      .o_in_ready  (o_in_ready),
      .o_wr_en     (o_wr_en),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_load_done (o_load_done),
      .o_load_err  (o_load_err),
      .o_err_code  (o_err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (o_mem_we === 1'b1) begin
         wq_addr.push_back(o_mem_addr);
         wq_data.push_back(o_mem_wdata);
         wq_wen.push_back(o_wr_en);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_log();
      wq_addr.delete();
      wq_data.delete();
      wq_wen.delete();
   endtask

   task automatic do_start();
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = b;
      for (int t = 0; t < 20 && !ok; t++) begin
         ok = (o_in_ready === 1'b1);
         @(posedge clk); #1;
      end
      i_in_valid = 1'b0;
      i_in_data  = 8'hEE;
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL handshake_timeout: byte %h never accepted (in_ready %b, want 1)", b, o_in_ready);
      end
   endtask

   task automatic send_len(input logic [31:0] len);
      for (int i = 0; i < 4; i++) send_byte(8'(len >> (8 * i)));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({stat, o_mem_addr, o_mem_wdata} !== 47'd0) begin
         n_fail++;
         $display("FAIL reset_values: stat %b addr %h data %h, want all zero", stat, o_mem_addr, o_mem_wdata);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (stat !== 7'b0000000) begin
         n_fail++;
         $display("FAIL idle_after_reset: stat %b want 0000000", stat);
      end
   endtask

   task automatic test_good_load();
      clear_log();
      do_start();
      n_cmp++;
      if (stat !== 7'b0000110) begin
         n_fail++;
         $display("FAIL good_start: stat %b want 0000110", stat);
      end
      send_len(32'd8);
      send_byte(pay[0]);
      n_cmp++;
      if ({o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, 32'd0, 8'h13}) begin
         n_fail++;
         $display("FAIL good_first_write: we %b addr %h data %h want 1/0/13", o_mem_we, o_mem_addr, o_mem_wdata);
      end
      for (int i = 1; i < 8; i++) send_byte(pay[i]);
      n_cmp++;
      if ({stat, o_mem_addr} !== {7'b0000111, 32'd7}) begin
         n_fail++;
         $display("FAIL good_last_write: stat %b addr %h want 0000111/7", stat, o_mem_addr);
      end
      send_byte(8'h4A);
      n_cmp++;
      if (stat !== 7'b1000000) begin
         n_fail++;
         $display("FAIL good_done: stat %b want 1000000", stat);
      end
      n_cmp++;
      if (wq_addr.size() !== 8) begin
         n_fail++;
         $display("FAIL good_write_count: got %0d want 8", wq_addr.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({wq_addr[i], wq_data[i], wq_wen[i]} !== {32'(i), pay[i], 1'b1}) begin
               n_fail++;
               $display("FAIL good_write_%0d: addr %h data %h wr_en %b want %h/%h/1",
                        i, wq_addr[i], wq_data[i], wq_wen[i], i, pay[i]);
            end
         end
      end
   endtask

   task automatic test_bad_csum();
      clear_log();
      do_start();
      n_cmp++;
      if (stat !== 7'b0000110) begin
         n_fail++;
         $display("FAIL badcs_start_clears: stat %b want 0000110", stat);
      end
      send_len(32'd8);
      for (int i = 0; i < 8; i++) send_byte(pay[i]);
      send_byte(8'h4B);
      n_cmp++;
      if (stat !== 7'b0111000) begin
         n_fail++;
         $display("FAIL badcs_status: stat %b want 0111000", stat);
      end
      n_cmp++;
      if (wq_addr.size() !== 8) begin
         n_fail++;
         $display("FAIL badcs_write_count: got %0d want 8", wq_addr.size());
      end
   endtask

   task automatic test_len_errors();
      logic [31:0] lens  [3] = '{32'd68, 32'd6, 32'd67};
      logic [6:0]  stats [3] = '{7'b0101000, 7'b0110000, 7'b0101000};
      for (int k = 0; k < 3; k++) begin
         clear_log();
         do_start();
         n_cmp++;
         if (stat !== 7'b0000110) begin
            n_fail++;
            $display("FAIL lenerr%0d_start_clears: stat %b want 0000110", k, stat);
         end
         send_len(lens[k]);
         n_cmp++;
         if (stat !== stats[k]) begin
            n_fail++;
            $display("FAIL lenerr%0d_status: len %0d stat %b want %b", k, lens[k], stat, stats[k]);
         end
         repeat (2) @(posedge clk);
         #1;
         n_cmp++;
         if (wq_addr.size() !== 0 || stat !== stats[k]) begin
            n_fail++;
            $display("FAIL lenerr%0d_hold: writes %0d stat %b want 0/%b", k, wq_addr.size(), stat, stats[k]);
         end
      end
   endtask

   task automatic test_empty_load();
      clear_log();
      do_start();
      send_len(32'd0);
      n_cmp++;
      if (stat !== 7'b0000110) begin
         n_fail++;
         $display("FAIL empty_csum_wait: stat %b want 0000110", stat);
      end
      send_byte(8'h00);
      n_cmp++;
      if (stat !== 7'b1000000 || wq_addr.size() !== 0) begin
         n_fail++;
         $display("FAIL empty_done: stat %b writes %0d want 1000000/0", stat, wq_addr.size());
      end
   endtask

   task automatic test_max_len();
      clear_log();
      do_start();
      send_len(32'd64);
      for (int i = 0; i < 64; i++) send_byte(8'(i));
      // payload 0..63 sums to 0x7E0, so 0x20 closes it to zero
      send_byte(8'h20);
      n_cmp++;
      if (stat !== 7'b1000000) begin
         n_fail++;
         $display("FAIL maxlen_done: stat %b want 1000000", stat);
      end
      n_cmp++;
      if (wq_addr.size() !== 64 || wq_addr[63] !== 32'd63 || wq_data[63] !== 8'd63) begin
         n_fail++;
         $display("FAIL maxlen_writes: count %0d last addr %h data %h want 64/3f/3f",
                  wq_addr.size(), wq_addr[wq_addr.size()-1], wq_data[wq_data.size()-1]);
      end
   endtask

   task automatic test_stall_and_start();
      clear_log();
      do_start();
      send_len(32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || i == 5) begin
            for (int g = 0; g < 3; g++) begin
               i_in_data = 8'hFF;
               i_start   = (g == 1);
               @(posedge clk); #1;
            end
            i_start = 1'b0;
            n_cmp++;
            if (stat !== 7'b0000110) begin
               n_fail++;
               $display("FAIL stall_gap_%0d: stat %b want 0000110", i, stat);
            end
         end
         send_byte(pay[i]);
      end
      send_byte(8'h4A);
      n_cmp++;
      if (stat !== 7'b1000000) begin
         n_fail++;
         $display("FAIL stall_done: stat %b want 1000000", stat);
      end
      n_cmp++;
      if (wq_addr.size() !== 8) begin
         n_fail++;
         $display("FAIL stall_write_count: got %0d want 8", wq_addr.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if ({wq_addr[i], wq_data[i]} !== {32'(i), pay[i]}) begin
               n_fail++;
               $display("FAIL stall_write_%0d: addr %h data %h want %h/%h", i, wq_addr[i], wq_data[i], i, pay[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_load();
      clear_log();
      do_start();
      send_len(32'd8);
      for (int i = 0; i < 3; i++) send_byte(pay[i]);
      rst_n = 1'b0;
      #2;
      n_cmp++;
      if ({stat, o_mem_addr, o_mem_wdata} !== 47'd0) begin
         n_fail++;
         $display("FAIL midreset_values: stat %b addr %h data %h want all zero", stat, o_mem_addr, o_mem_wdata);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (stat !== 7'b0000000) begin
         n_fail++;
         $display("FAIL midreset_idle: stat %b want 0000000", stat);
      end
      clear_log();
      do_start();
      send_len(32'd8);
      for (int i = 0; i < 8; i++) send_byte(pay[i]);
      send_byte(8'h4A);
      n_cmp++;
      if (stat !== 7'b1000000 || wq_addr.size() !== 8) begin
         n_fail++;
         $display("FAIL midreset_reload: stat %b writes %0d want 1000000/8", stat, wq_addr.size());
      end
   endtask

   initial begin
      test_reset();
      test_good_load();
      test_bad_csum();
      test_len_errors();
      test_empty_load();
      test_max_len();
      test_stall_and_start();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader on the upstream side of instruction memory. Accepts a byte stream (length header, payload, checksum) over a valid/ready handshake and writes each payload byte into IMEM at consecutive byte addresses starting at 0. While loading it holds `wr_en` high, which freezes instruction fetch. On completion it reports success or a specific error.

## Interface
- `MEM_WIDTH`, default `MEM_WIDTH` (8): IMEM entry width; one byte per entry.
- `PC_WIDTH`, default `PC_WIDTH` (32): byte-address width.
- `IMEM_DEPTH`, default `IMEM_DEPTH`: number of IMEM entries; sets the maximum load length.
- `clk` in 1: single clock. All logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a load.
- `in_valid` in 1: stream byte valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte.
- `wr_en` out 1: load in progress; fetch is frozen while high.
- `mem_we` out 1: per-byte IMEM write strobe.
- `mem_addr` out PC_WIDTH: write byte address.
- `mem_wdata` out MEM_WIDTH: write byte.
- `load_done` out 1: last load succeeded (level).
- `load_err` out 1: last load failed (level).
- `err_code` out 2: error cause: 01 length > IMEM_DEPTH, 10 length not a multiple of 4, 11 checksum mismatch, 00 none.

## Operation
- **Stream format:** 4 length bytes (little-endian, payload byte count L), then L payload bytes, then 1 checksum byte C. A load is valid when (sum of payload bytes + C) mod 256 == 0.
- **States:** IDLE, LEN, DATA, CSUM, DONE, ERR.
- **IDLE / DONE / ERR:**
  - `start` goes to LEN.
  - It clears `load_done`, `load_err`, `err_code`, the byte counter, the checksum accumulator and the address.
  - `start` is ignored in LEN, DATA and CSUM.
- **LEN:** accepts 4 bytes into the length register, LSB first. After the 4th byte:
  - L > IDLE_DEPTH limit (L > IMEM_DEPTH) goes to ERR with code 01.
  - Else L[1:0] != 0 goes to ERR with code 10. Code 01 wins if both conditions hold.
  - Else L == 0 goes to CSUM.
  - Else goes to DATA.
- **DATA:**
  - Each accepted byte issues one IMEM write at the current address, then address += 1.
  - Each byte is added into the 8-bit accumulator, wrapping mod 256.
  - After byte L, goes to CSUM.
- **CSUM:** accepts 1 byte.
  - If accumulator + byte == 0 mod 256, goes to DONE (`load_done`=1).
  - Else goes to ERR (`load_err`=1, code 11).
- **Memory on failure:** bytes already written on an error path stay in IMEM. No rollback.
- **Reset mid-load:** returns to IDLE immediately and all outputs return to reset values. IMEM contents are left as partially written.

## Timing
- **Reset values:** `in_ready`=0, `wr_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `load_done`=0, `load_err`=0, `err_code`=00. State is IDLE.
- **Handshake:** a byte transfers on a rising edge with `in_valid` && `in_ready`.
  - `in_ready` is high in LEN, DATA and CSUM, and low elsewhere. It is a registered function of state.
  - `in_valid` may toggle freely. Gaps stall progress with no timeout.
- **`wr_en`:** rises the cycle after `start` is sampled. It falls the cycle the FSM enters DONE or ERR, after the last `mem_we` pulse.
- **Write latency:** `mem_we`, `mem_addr` and `mem_wdata` are registered. They are valid the cycle after the payload byte is accepted, with `mem_we` a 1-cycle pulse per byte. Back-to-back bytes produce back-to-back strobes.
- **Final byte:** the last payload byte is accepted on edge N. Its `mem_we` is high in cycle N+1, and `in_ready` stays high for the checksum byte.
- **Status:** `load_done` / `load_err` assert the cycle after the checksum byte (or the failing length byte) is accepted. They hold until the next accepted `start` or reset.
- **Address width:** the byte counter and address are PC_WIDTH wide. L is limited to IMEM_DEPTH, so the address never exceeds IMEM_DEPTH-1.

## Structure
- **Shared package:**
  - state encoding (3 bits);
  - error codes ERR_NONE, ERR_LEN_RANGE, ERR_LEN_ALIGN, ERR_CSUM;
  - header length constant LDR_HDR_BYTES = 4.
- **Sub-module `ld_checksum`:** 8-bit accumulator with clear, add-enable and a combinational "sum with byte is zero" check.

## Test plan
- **Good load:** `start`, length bytes 08 00 00 00, payload 13 00 00 00 93 00 10 00, checksum 0x4A -> 8 `mem_we` pulses at addresses 0..7 with matching data; `load_done`=1, `err_code`=00, `wr_en` falls after the address-7 write.
- **Bad checksum:** same stream with checksum 0x4B -> 8 writes occur; `load_err`=1, `err_code`=11, `load_done`=0.
- **Length too large:** length = IMEM_DEPTH+4 -> no `mem_we`; ERR with code 01 one cycle after the 4th length byte; `in_ready`=0.
- **Misaligned / empty length:**
  - length 06 00 00 00 -> ERR with code 10, no writes.
  - length 0 followed by checksum 00 -> DONE, no writes.
- **Stalls and ignored start:** `in_valid` low for 3 cycles between payload bytes, plus `start` pulsed during DATA -> writes stay in order with no duplicates, and the `start` has no effect.
- **Reset mid-load:** `reset_n` low after payload byte 3 -> all outputs at reset values; a fresh `start` load then completes normally.
